// File: rtl/thor2024_regfile_source_pkg.sv
// Thor2024 shared types: producer tags, register and IQ index widths.
// Shared by the regfile source table and the register-valid tracker.
package Thor2024pkg;

  localparam int AREGS    = 64;
  localparam int QENTRIES = 8;
  localparam int TAGW     = 5;
  localparam logic [5:0] LR0 = 6'd56;

  typedef logic [TAGW-1:0] tag_t;
  typedef logic [5:0]      areg_t;
  typedef logic [2:0]      qidx_t;
  typedef logic [1:0]      gen_t;

  function automatic tag_t mk_tag(gen_t g, qidx_t s);
    return {g, s};
  endfunction

endpackage

// File: rtl/thor2024_regfile_source_youngest.sv
// Youngest surviving producer per target, ordered circularly from head0.
// An entry is flagged when no younger survivor writes the same register.
module thor2024_youngest_producer
  import Thor2024pkg::*;
(
  input  qidx_t                      head0,
  input  logic  [QENTRIES-1:0]       surv,
  input  areg_t [QENTRIES-1:0]       tgt,
  output logic  [QENTRIES-1:0]       src
);

  qidx_t [QENTRIES-1:0] age;

  always_comb begin
    for (int i = 0; i < QENTRIES; i++) begin
      age[i] = qidx_t'(i) - head0;
    end
  end

  always_comb begin
    src = surv;
    for (int i = 0; i < QENTRIES; i++) begin
      for (int j = 0; j < QENTRIES; j++) begin
        if (j != i && surv[j] &&
            tgt[j] == tgt[i] &&
            age[j] > age[i]) begin
          src[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/thor2024_regfile_source.sv
// Register source-tag table: per-register producer tags, written at
// enqueue and rebuilt from surviving IQ entries on a branch miss.
module thor2024_regfile_source
  import Thor2024pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   branchmiss,
  input  logic                   did_branchback,
  input  logic                   fetchbuf0_v,
  input  logic                   fetchbuf1_v,
  input  logic                   fetchbuf0_rfw,
  input  logic                   fetchbuf1_rfw,
  input  logic                   fetchbuf0_backbr,
  input  logic                   fetchbuf0_lk,
  input  areg_t                  Rt0,
  input  areg_t                  Rt1,
  input  qidx_t                  head0,
  input  qidx_t                  tail0,
  input  qidx_t                  tail1,
  input  logic  [QENTRIES-1:0]   iq_v,
  input  logic  [QENTRIES-1:0]   iq_rfw,
  input  areg_t [QENTRIES-1:0]   iq_tgt,
  input  logic  [QENTRIES-1:0]   iq_squash,
  output tag_t  [AREGS-1:0]      rf_source,
  output logic  [AREGS-1:1]      livetarget,
  output logic  [QENTRIES-1:0]   iqentry_source,
  output tag_t                   enq_tag0,
  output tag_t                   enq_tag1
);

  tag_t [AREGS-1:0]    rf_q, rf_d;
  gen_t [QENTRIES-1:0] gen_q, gen_d;
  logic [QENTRIES-1:0] surv;
  gen_t                gen0_n, gen1_n;
  logic                enq_ok, both_v;

  assign surv = iq_v & ~iq_squash & iq_rfw;

  thor2024_youngest_producer u_young (
    .head0 (head0),
    .surv  (surv),
    .tgt   (iq_tgt),
    .src   (iqentry_source)
  );

  always_comb begin
    for (int r = 1; r < AREGS; r++) begin
      livetarget[r] = 1'b0;
      for (int i = 0; i < QENTRIES; i++) begin
        if (surv[i] && iq_tgt[i] == areg_t'(r)) begin
          livetarget[r] = 1'b1;
        end
      end
    end
  end

  assign gen0_n   = gen_q[tail0] + 2'd1;
  assign gen1_n   = gen_q[tail1] + 2'd1;
  assign enq_tag0 = mk_tag(gen0_n, tail0);
  assign enq_tag1 = mk_tag(gen1_n, tail1);
  assign enq_ok   = !iq_v[tail0] && !did_branchback;
  assign both_v   = fetchbuf0_v && fetchbuf1_v;

  always_comb begin
    rf_d  = rf_q;
    gen_d = gen_q;
    if (branchmiss) begin
      for (int i = 0; i < QENTRIES; i++) begin
        if (iqentry_source[i]) begin
          rf_d[iq_tgt[i]] = mk_tag(gen_q[i], qidx_t'(i));
        end
      end
    end else if (enq_ok) begin
      unique case (1'b1)
        (!fetchbuf0_v && fetchbuf1_v): begin
          if (fetchbuf1_rfw) rf_d[Rt1] = enq_tag0;
          gen_d[tail0] = gen0_n;
        end
        (both_v && fetchbuf0_backbr): begin
          if (fetchbuf0_lk) rf_d[LR0] = enq_tag0;
          gen_d[tail0] = gen0_n;
        end
        (both_v && !fetchbuf0_backbr && !iq_v[tail1]): begin
          // slot 1 written last so it wins a shared target
          if (fetchbuf0_rfw) rf_d[Rt0] = enq_tag0;
          if (fetchbuf1_rfw) rf_d[Rt1] = enq_tag1;
          gen_d[tail0] = gen0_n;
          gen_d[tail1] = gen1_n;
        end
        (both_v && !fetchbuf0_backbr && iq_v[tail1]): begin
          if (fetchbuf0_rfw) rf_d[Rt0] = enq_tag0;
          gen_d[tail0] = gen0_n;
        end
        default: ;
      endcase
    end
    rf_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q  <= '0;
      gen_q <= '0;
    end else begin
      rf_q  <= rf_d;
      gen_q <= gen_d;
    end
  end

  assign rf_source = rf_q;

endmodule

// File: tb/tb_thor2024_regfile_source.sv
// Directed vector bench for the Thor2024 register source-tag table.
// Expected tags are hand-computed from the running gen state.
module tb_thor2024_regfile_source;
  import Thor2024pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 branchmiss, did_branchback;
  logic                 fetchbuf0_v, fetchbuf1_v;
  logic                 fetchbuf0_rfw, fetchbuf1_rfw;
  logic                 fetchbuf0_backbr, fetchbuf0_lk;
  areg_t                Rt0, Rt1;
  qidx_t                head0, tail0, tail1;
  logic  [QENTRIES-1:0] iq_v, iq_rfw, iq_squash;
  areg_t [QENTRIES-1:0] iq_tgt;
  tag_t  [AREGS-1:0]    rf_source;
  logic  [AREGS-1:1]    livetarget;
  logic  [QENTRIES-1:0] iqentry_source;
  tag_t                 enq_tag0, enq_tag1;

  int total = 0;
  int bad   = 0;

  thor2024_regfile_source dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .branchmiss       (branchmiss),
    .did_branchback   (did_branchback),
    .fetchbuf0_v      (fetchbuf0_v),
    .fetchbuf1_v      (fetchbuf1_v),
    .fetchbuf0_rfw    (fetchbuf0_rfw),
    .fetchbuf1_rfw    (fetchbuf1_rfw),
    .fetchbuf0_backbr (fetchbuf0_backbr),
    .fetchbuf0_lk     (fetchbuf0_lk),
    .Rt0              (Rt0),
    .Rt1              (Rt1),
    .head0            (head0),
    .tail0            (tail0),
    .tail1            (tail1),
    .iq_v             (iq_v),
    .iq_rfw           (iq_rfw),
    .iq_tgt           (iq_tgt),
    .iq_squash        (iq_squash),
    .rf_source        (rf_source),
    .livetarget       (livetarget),
    .iqentry_source   (iqentry_source),
    .enq_tag0         (enq_tag0),
    .enq_tag1         (enq_tag1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v0, v1, rfw0, rfw1, bb, lk, dbb;
    logic [5:0] rt0, rt1;
    logic [2:0] t0, t1;
    logic [7:0] iqv;
    logic [4:0] et0, et1;
    logic [5:0] ca;
    logic [4:0] ea;
    logic [5:0] cb;
    logic [4:0] eb;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    branchmiss       = 1'b0;
    did_branchback   = 1'b0;
    fetchbuf0_v      = 1'b0;
    fetchbuf1_v      = 1'b0;
    fetchbuf0_rfw    = 1'b0;
    fetchbuf1_rfw    = 1'b0;
    fetchbuf0_backbr = 1'b0;
    fetchbuf0_lk     = 1'b0;
    Rt0 = '0; Rt1 = '0;
    head0 = '0; tail0 = '0; tail1 = '0;
    iq_v = '0; iq_rfw = '0; iq_squash = '0; iq_tgt = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int nz;

  initial begin
    vecs[0]  = '{1,1,1,1,0,0,0, 5, 5,2,3,8'h00,5'h0A,5'h0B, 5,5'h0B, 5,5'h0B};
    vecs[1]  = '{1,1,1,0,0,0,0, 5, 5,4,5,8'h00,5'h0C,5'h0D, 5,5'h0C, 5,5'h0C};
    vecs[2]  = '{1,1,1,1,0,0,0, 9,10,2,3,8'h00,5'h12,5'h13, 9,5'h12,10,5'h13};
    vecs[3]  = '{1,1,1,1,1,1,0,20,21,4,5,8'h00,5'h14,5'h15,56,5'h14,21,5'h00};
    vecs[4]  = '{1,0,1,0,0,0,0,22, 0,6,7,8'h00,5'h0E,5'h0F,22,5'h00,22,5'h00};
    vecs[5]  = '{0,1,0,1,0,0,0,22,23,6,7,8'h00,5'h0E,5'h0F,23,5'h0E,22,5'h00};
    vecs[6]  = '{1,1,1,1,0,0,0,24,25,7,0,8'h01,5'h0F,5'h08,24,5'h0F,25,5'h00};
    vecs[7]  = '{1,1,1,1,0,0,0,26,26,7,0,8'h80,5'h17,5'h08,26,5'h00,26,5'h00};
    vecs[8]  = '{1,1,1,1,0,0,1,27,28,1,2,8'h00,5'h09,5'h1A,27,5'h00,28,5'h00};
    vecs[9]  = '{1,1,1,1,0,0,0,30, 0,1,2,8'h00,5'h09,5'h1A,30,5'h09, 0,5'h00};
    vecs[10] = '{1,1,1,1,0,0,0,31,32,2,3,8'h00,5'h02,5'h1B,31,5'h02,32,5'h1B};

    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nz = 0;
    for (int r = 0; r < AREGS; r++) if (rf_source[r] != '0) nz++;
    chk("reset_rf_nonzero", nz, 0);
    chk("reset_tag0", enq_tag0, 5'h08);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 11; k++) begin
      fetchbuf0_v      = vecs[k].v0;
      fetchbuf1_v      = vecs[k].v1;
      fetchbuf0_rfw    = vecs[k].rfw0;
      fetchbuf1_rfw    = vecs[k].rfw1;
      fetchbuf0_backbr = vecs[k].bb;
      fetchbuf0_lk     = vecs[k].lk;
      did_branchback   = vecs[k].dbb;
      Rt0   = vecs[k].rt0;
      Rt1   = vecs[k].rt1;
      tail0 = vecs[k].t0;
      tail1 = vecs[k].t1;
      iq_v  = vecs[k].iqv;
      #1;
      chk($sformatf("v%0d_tag0", k), enq_tag0, vecs[k].et0);
      chk($sformatf("v%0d_tag1", k), enq_tag1, vecs[k].et1);
      tick();
      chk($sformatf("v%0d_rf%0d", k, vecs[k].ca),
          rf_source[vecs[k].ca], vecs[k].ea);
      chk($sformatf("v%0d_rf%0d", k, vecs[k].cb),
          rf_source[vecs[k].cb], vecs[k].eb);
    end

    // branch miss with a same-cycle enqueue attempt
    idle();
    iq_v      = 8'b0000_1010;
    iq_rfw    = 8'b0000_1010;
    iq_tgt[1] = 6'd7;
    iq_tgt[3] = 6'd7;
    #1;
    chk("ysrc_head0", iqentry_source, 8'b0000_1000);
    head0 = 3'd2;
    #1;
    chk("ysrc_head2", iqentry_source, 8'b0000_0010);
    head0 = 3'd0;
    iq_squash  = 8'b0000_1000;
    branchmiss = 1'b1;
    fetchbuf0_v = 1'b1; fetchbuf1_v = 1'b1;
    fetchbuf0_rfw = 1'b1; fetchbuf1_rfw = 1'b1;
    Rt0 = 6'd40; Rt1 = 6'd40;
    tail0 = 3'd4; tail1 = 3'd5;
    #1;
    chk("bm_live7", livetarget[7], 1'b1);
    chk("bm_live8", livetarget[8], 1'b0);
    chk("bm_ysrc", iqentry_source, 8'b0000_0010);
    tick();
    chk("bm_rf7", rf_source[7], 5'h09);
    chk("bm_rf40", rf_source[40], 5'h00);
    branchmiss = 1'b0;
    fetchbuf0_v = 1'b0; fetchbuf1_v = 1'b0;
    #1;
    chk("bm_gen4_kept", enq_tag0, 5'h1C);
    chk("bm_rf5_kept", rf_source[5], 5'h0C);

    // asynchronous reset mid-cycle
    idle();
    tail0 = 3'd3;
    #2;
    rst_n = 1'b0;
    #1;
    nz = 0;
    for (int r = 0; r < AREGS; r++) if (rf_source[r] != '0) nz++;
    chk("midrst_rf_nonzero", nz, 0);
    chk("midrst_tag0", enq_tag0, 5'h0B);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // generation wrap on IQ slot 0, target r0
    fetchbuf1_v = 1'b1; fetchbuf1_rfw = 1'b1;
    Rt1 = 6'd0; tail0 = 3'd0; tail1 = 3'd1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] g;
      g = 2'(k + 1);
      #1;
      chk($sformatf("wrap%0d_tag0", k), enq_tag0, {g, 3'd0});
      tick();
      chk($sformatf("wrap%0d_rf0", k), rf_source[0], 5'h00);
    end
    Rt1 = 6'd12;
    #1;
    chk("wrap_again_tag0", enq_tag0, 5'h08);
    tick();
    chk("wrap_rf12", rf_source[12], 5'h08);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
